// File: rtl/gate_phase_stream_if.sv
// Amplitude stream bundle: input side (valid/ready/re/im) and output side
// (valid/ready/re/im/last) of the phase-gate datapath.
interface gate_phase_stream_if #(
  parameter int DW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic                 out_last;

  // the gate itself: consumes input stream, produces output stream
  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last
  );

  // producer/consumer around the gate
  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last
  );
endinterface

// File: rtl/gate_phase_stream.sv
// Streaming (controlled-)phase gate. Consumes the 2**NQ amplitudes of one
// state vector in index order and multiplies the selected ones by
// cos + i*sin (Q1.FRAC), with round-half-up and saturation. Three-stage
// pipeline that freezes as a whole while the output is stalled.
module gate_phase_stream #(
  parameter int DW   = 16,
  parameter int FRAC = 15,
  parameter int NQ   = 4,
  localparam int TW  = (NQ > 1) ? $clog2(NQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [DW-1:0] cos_theta,
  input  logic signed [DW-1:0] sin_theta,
  input  logic [TW-1:0]        target,
  input  logic [NQ-1:0]        ctrl_mask,
  gate_phase_stream_if.slave   s,
  output logic                 busy,
  output logic                 done
);
  localparam int N      = 2**NQ;
  localparam int STAGES = 3;
  localparam int PW     = 2*DW + 1;
  localparam logic signed [PW-1:0] SMAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = ~SMAX;
  localparam logic signed [PW-1:0] RND  = (FRAC > 0) ? (PW'(1) << (FRAC-1)) : '0;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // one amplitude travelling through S1/S2, with its rotate/last tags
  typedef struct packed {
    logic                 rot;
    logic                 last;
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } amp_t;

  state_t                 state;
  logic [NQ:0]            in_idx, out_idx;
  logic signed [DW-1:0]   cos_q, sin_q;
  logic [TW-1:0]          tgt_q;
  logic [NQ-1:0]          mask_q;
  logic [STAGES:1]        vld_pipe;
  amp_t                   s1, s2;
  logic signed [2*DW-1:0] p_rc, p_is, p_rs, p_ic;
  logic signed [DW-1:0]   ore, oim;
  logic                   olast;
  logic                   stall, in_rdy, in_fire, out_fire, rot_in;
  logic [NQ-1:0]          idx_lo;
  logic signed [PW-1:0]   sum_re, sum_im, sh_re, sh_im;

  function automatic logic signed [DW-1:0] sat(input logic signed [PW-1:0] v);
    if (v > SMAX)      return SMAX[DW-1:0];
    else if (v < SMIN) return SMIN[DW-1:0];
    else               return v[DW-1:0];
  endfunction

  assign stall    = vld_pipe[STAGES] && !s.out_ready;
  assign in_rdy   = (state == RUN) && !in_idx[NQ] && !stall;
  assign in_fire  = s.in_valid && in_rdy;
  assign out_fire = vld_pipe[STAGES] && s.out_ready;

  // selection uses the index of the amplitude being accepted
  assign idx_lo = in_idx[NQ-1:0];
  assign rot_in = |(idx_lo & (NQ'(1) << tgt_q)) && ((idx_lo & mask_q) == mask_q);

  // S3 combine: sums are one bit wider than products so they never wrap
  assign sum_re = PW'(p_rc) - PW'(p_is) + RND;
  assign sum_im = PW'(p_rs) + PW'(p_ic) + RND;
  assign sh_re  = sum_re >>> FRAC;
  assign sh_im  = sum_im >>> FRAC;

  assign s.in_ready  = in_rdy;
  assign s.out_valid = vld_pipe[STAGES];
  assign s.out_re    = ore;
  assign s.out_im    = oim;
  assign s.out_last  = olast;

  // vector sequencing, coefficient latch, counters, busy/done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      in_idx  <= '0;
      out_idx <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      tgt_q   <= '0;
      mask_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cos_q   <= cos_theta;
          sin_q   <= sin_theta;
          tgt_q   <= target;
          mask_q  <= ctrl_mask;
          in_idx  <= '0;
          out_idx <= '0;
          busy    <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          if (in_fire) in_idx <= in_idx + 1'b1;
          if (out_fire) begin
            out_idx <= out_idx + 1'b1;
            if (out_idx == (NQ+1)'(N-1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // datapath: all stages advance together unless the output is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      p_rc     <= '0;
      p_is     <= '0;
      p_rs     <= '0;
      p_ic     <= '0;
      ore      <= '0;
      oim      <= '0;
      olast    <= 1'b0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_fire};
      s1.rot   <= rot_in;
      s1.last  <= (idx_lo == {NQ{1'b1}});
      s1.re    <= s.in_re;
      s1.im    <= s.in_im;
      s2       <= s1;
      p_rc     <= $signed(s1.re) * cos_q;
      p_is     <= $signed(s1.im) * sin_q;
      p_rs     <= $signed(s1.re) * sin_q;
      p_ic     <= $signed(s1.im) * cos_q;
      olast    <= vld_pipe[2] && s2.last;
      if (vld_pipe[2]) begin
        ore <= s2.rot ? sat(sh_re) : s2.re;
        oim <= s2.rot ? sat(sh_im) : s2.im;
      end
    end
  end
endmodule
